seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for N_DIGITS hexadecimal 7-segment digits; parametrised successor to the single-digit decoder.
- Adds double-buffered data load with frame-boundary update, per-digit blanking, blinking and decimal points, leading-zero suppression, and anti-ghost guard time.
- Sits between the Hamming datapath (corrected data, syndrome) and the board display pins.

---
 rtl/seg7_scan_driver.sv | 157 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex 7-segment driver: double-buffered data with
// frame-boundary update, blank/blink/dp per digit, leading-zero suppression, anti-ghost guard.
module seg7_scan_driver #(
    parameter int N_DIGITS       = 4,
    parameter int SCAN_DIV       = 6750,
    parameter int GUARD          = 16,
    parameter int BLINK_FRAMES   = 250,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_AN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  lz_suppress,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int SLOT_W  = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int DIG_W   = (N_DIGITS > 1)     ? $clog2(N_DIGITS)     : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(N_DIGITS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
    localparam logic [SLOT_W-1:0]  GUARD_END  = SLOT_W'(GUARD);

    // Internal logic is active-low; these masks flip it at the pins when needed.
    localparam logic [6:0]          SEG_XOR = ACTIVE_LOW_SEG ? 7'h00 : 7'h7F;
    localparam logic [N_DIGITS-1:0] AN_XOR  = ACTIVE_LOW_AN  ? '0    : '1;

    logic [SLOT_W-1:0]     r_slot_cnt;
    logic [DIG_W-1:0]      r_digit;
    logic [FRAME_W-1:0]    r_frame_cnt;
    logic                  r_blink_phase;
    logic [4*N_DIGITS-1:0] r_staging;
    logic [4*N_DIGITS-1:0] r_display;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [N_DIGITS-1:0]   r_an;
    logic                  r_frame_done;

    logic                  w_slot_wrap;
    logic                  w_frame_boundary;
    logic [SLOT_W-1:0]     w_slot_next;
    logic [DIG_W-1:0]      w_digit_next;
    logic [N_DIGITS-1:0]   w_digit_blank;
    logic [3:0]            w_cur_nib;
    logic                  w_cur_blank;
    logic [N_DIGITS-1:0]   w_onehot;
    logic [6:0]            w_seg_al;
    logic                  w_dp_al;
    logic [N_DIGITS-1:0]   w_an_al;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign w_slot_wrap      = (r_slot_cnt == SLOT_LAST);
    assign w_frame_boundary = w_slot_wrap && (r_digit == DIG_LAST);
    assign w_slot_next      = w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
    assign w_digit_next     = !w_slot_wrap         ? r_digit :
                              (r_digit == DIG_LAST) ? '0      : r_digit + 1'b1;

    // Walk from the most significant digit down so the zero run is known at each k.
    always_comb begin
        logic w_zero_run;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_zero_run    = 1'b1;
        w_digit_blank = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            w_zero_run       = w_zero_run && (r_display[4*k +: 4] == 4'h0);
            w_digit_blank[k] = blank_mask[k]
                             | (blink_mask[k] & r_blink_phase)
                             | (lz_suppress & (k != 0) & w_zero_run);
        end
    end

    assign w_cur_nib   = r_display[4*r_digit +: 4];
    assign w_cur_blank = w_digit_blank[r_digit];
    assign w_onehot    = N_DIGITS'(1) << r_digit;
    assign w_seg_al    = w_cur_blank ? 7'h7F : hex_glyph(w_cur_nib);
    assign w_dp_al     = ~(dp_in[r_digit] & ~w_cur_blank);
    assign w_an_al     = (r_slot_cnt < GUARD_END) ? '1 : ~w_onehot;

    // Scan counters, blink phase and the double-buffered digit data.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_slot_cnt    <= '0;
            r_digit       <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_staging     <= '0;
            r_display     <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_slot_cnt   <= w_slot_next;
            r_digit      <= w_digit_next;
            r_frame_done <= (w_slot_next == SLOT_LAST) && (w_digit_next == DIG_LAST);
            if (load) begin
                r_staging <= data_in;
            end
            if (w_frame_boundary) begin
                // A load landing on the boundary itself goes straight to the display.
                r_display <= load ? data_in : r_staging;
                if (r_frame_cnt == FRAME_LAST) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= 7'h7F ^ SEG_XOR;
            r_dp  <= 1'b1 ^ SEG_XOR[0];
            r_an  <= ~AN_XOR;
        end else begin
            r_seg <= w_seg_al ^ SEG_XOR;
            r_dp  <= w_dp_al ^ SEG_XOR[0];
            r_an  <= w_an_al ^ AN_XOR;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 4-cycle slots, 1-cycle guard, 2-frame blink):
// per-cycle expectations are queued per frame and popped as the scan produces them.
module tb_seg7_scan_driver;

    localparam int N_DIGITS     = 4;
    localparam int SCAN_DIV     = 4;
    localparam int GUARD        = 1;
    localparam int BLINK_FRAMES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic        load;
    logic [3:0]  dp_in;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic        lz_suppress;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    typedef struct {
        logic       disp;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   frame_idx = 0;

    seg7_scan_driver #(
        .N_DIGITS      (N_DIGITS),
        .SCAN_DIV      (SCAN_DIV),
        .GUARD         (GUARD),
        .BLINK_FRAMES  (BLINK_FRAMES),
        .ACTIVE_LOW_SEG(1'b1),
        .ACTIVE_LOW_AN (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load       (load),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .lz_suppress(lz_suppress),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".seg"}, 16'(seg), 16'h007F);
        check({tag, ".dp"}, 16'(dp), 16'h0001);
        check({tag, ".an"}, 16'(an), 16'h000F);
        check({tag, ".frame_done"}, 16'(frame_done), 16'h0000);
    endtask

    // Steps negedges until frame_done is seen, returning how many it took.
    task automatic wait_frame_done(input string tag, output int cnt);
        cnt = 0;
        while (frame_done !== 1'b1 && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, ".frame_done_seen"}, 16'(frame_done), 16'h0001);
    endtask

    // Entered on the negedge where frame_done is high; leaves on the next such negedge.
    // Entry 0 still shows the previous frame's last cycle, so only frame_done is checked there.
    task automatic check_frame(input string name,
                               input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input logic [3:0] dp_on,
                               input int load_step, input logic [15:0] load_data);
        logic [6:0] glyphs [4];
        exp_t e;
        glyphs = '{s0, s1, s2, s3};
        for (int i = 0; i < 16; i++) begin
            int j;
            j      = i - 1;
            e.disp = (i != 0);
            e.fd   = (i == 15);
            e.an   = 4'h0;
            e.seg  = 7'h00;
            e.dp   = 1'b0;
            if (i != 0) begin
                e.an  = ((j % SCAN_DIV) < GUARD) ? 4'hF : ~(4'b0001 << (j / SCAN_DIV));
                e.seg = glyphs[j / SCAN_DIV];
                e.dp  = ~dp_on[j / SCAN_DIV];
            end
            sb_q.push_back(e);
        end
        for (int i = 0; i < 16; i++) begin
            if (i == load_step) begin
                data_in = load_data;
                load    = 1'b1;
            end
            @(negedge clk);
            load = 1'b0;
            e = sb_q.pop_front();
            check($sformatf("%s[%0d].frame_done", name, i), 16'(frame_done), 16'(e.fd));
            if (e.disp) begin
                check($sformatf("%s[%0d].an", name, i), 16'(an), 16'(e.an));
                check($sformatf("%s[%0d].seg", name, i), 16'(seg), 16'(e.seg));
                check($sformatf("%s[%0d].dp", name, i), 16'(dp), 16'(e.dp));
            end
        end
        frame_idx++;
    endtask

    initial begin
        int cnt;
        logic ph;
        rst         = 1'b1;
        load        = 1'b0;
        data_in     = 16'h0000;
        dp_in       = 4'b0000;
        blank_mask  = 4'b0000;
        blink_mask  = 4'b0000;
        lz_suppress = 1'b0;

        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // First slot after release: guard cycle, then digit 0 selected.
        @(negedge clk);
        check("first_guard.an", 16'(an), 16'h000F);
        check("first_guard.seg", 16'(seg), 16'h0040);
        @(negedge clk);
        check("first_active.an", 16'(an), 16'h000E);
        wait_frame_done("first_frame", cnt);
        check("first_frame.latency", 16'(cnt), 16'd13);

        frame_idx = 1;
        check_frame("blank_display", 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, -1, 16'h0000);
        check_frame("load_mid_frame", 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 6, 16'h12AF);
        check_frame("after_load", 7'h0E, 7'h08, 7'h24, 7'h79, 4'b0000, -1, 16'h0000);
        check_frame("bypass_load", 7'h12, 7'h40, 7'h40, 7'h40, 4'b0000, 0, 16'h0005);

        lz_suppress = 1'b1;
        check_frame("lz_0005", 7'h12, 7'h7F, 7'h7F, 7'h7F, 4'b0000, -1, 16'h0000);
        check_frame("lz_0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 0, 16'h0000);
        check_frame("lz_0105", 7'h12, 7'h40, 7'h79, 7'h7F, 4'b0000, 0, 16'h0105);
        lz_suppress = 1'b0;

        // Blink phase flips every second frame boundary counted from reset.
        blink_mask = 4'b0010;
        for (int f = 0; f < 4; f++) begin
            ph = (((frame_idx / BLINK_FRAMES) % 2) == 1);
            check_frame($sformatf("blink%0d", f), 7'h30, ph ? 7'h7F : 7'h30, 7'h30, 7'h30,
                        4'b0000, (f == 0) ? 0 : -1, 16'h3333);
        end
        blink_mask = 4'b0000;

        dp_in      = 4'b0100;
        blank_mask = 4'b0100;
        check_frame("dp_blanked", 7'h30, 7'h30, 7'h7F, 7'h30, 4'b0000, -1, 16'h0000);
        blank_mask = 4'b0000;
        check_frame("dp_visible", 7'h30, 7'h30, 7'h30, 7'h30, 4'b0100, -1, 16'h0000);

        // Reset while digit 2 is actively selected.
        repeat (11) @(negedge clk);
        check("pre_reset.an", 16'(an), 16'h000B);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid_reset");
        rst = 1'b0;
        @(negedge clk);
        check("restart_guard.an", 16'(an), 16'h000F);
        check("restart_guard.seg", 16'(seg), 16'h0040);
        check("restart_guard.dp", 16'(dp), 16'h0001);
        @(negedge clk);
        check("restart_active.an", 16'(an), 16'h000E);
        check("restart_active.seg", 16'(seg), 16'h0040);
        wait_frame_done("restart_frame", cnt);
        check("restart_frame.latency", 16'(cnt), 16'd13);
        frame_idx = 1;
        check_frame("post_reset", 7'h40, 7'h40, 7'h40, 7'h40, 4'b0100, -1, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
